// File: rtl/gray_sobel_pkg.sv
// rtl/gray_sobel_pkg.sv - shared types and widths for the gray/Sobel pixel pipeline
package gray_sobel_pkg;

  localparam int MAX_PIXEL_BITS  = 24;
  localparam int PIXEL_WIDTH_OUT = 8;

  typedef enum logic [1:0] {
    SEL_GRAY       = 2'b00,
    SEL_SOBEL      = 2'b01,
    SEL_GRAY_SOBEL = 2'b10,
    SEL_BYPASS     = 2'b11
  } sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/px_fifo.sv
// rtl/px_fifo.sv - small pixel-entry FIFO with synchronous flush
module px_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wr_data_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Storage needs no reset; validity is tracked entirely by count.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data_o = mem[rd_ptr];
  assign full_o    = (count == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count == '0);

endmodule

// File: rtl/pixel_byte_serializer.sv
// rtl/pixel_byte_serializer.sv - buffers processed pixels and streams them out LSB-first as bytes
module pixel_byte_serializer
  import gray_sobel_pkg::*;
#(
  parameter int PIXEL_W    = MAX_PIXEL_BITS,
  parameter int PX_OUT_W   = PIXEL_WIDTH_OUT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic [1:0]         select_i,
  input  logic               px_valid_i,
  input  logic [PIXEL_W-1:0] px_i,
  input  logic               flush_i,
  output logic [7:0]         byte_o,
  output logic               byte_valid_o,
  input  logic               byte_ready_i,
  output logic               fifo_full_o,
  output logic               overflow_o,
  output logic               busy_o
);

  localparam int NBYTES = PIXEL_W / 8;
  localparam int NB_W   = $clog2(NBYTES + 1);
  localparam int EW     = PIXEL_W + NB_W;
  localparam logic [7:0] OUT_MASK = 8'((16'd1 << PX_OUT_W) - 16'd1);

  ser_state_t         state;
  logic [PIXEL_W-1:0] shift_q;
  logic [NB_W-1:0]    nbytes_q;
  logic [NB_W-1:0]    idx_q;
  logic               overflow_q;

  logic [PIXEL_W-1:0] wr_px;
  logic [NB_W-1:0]    wr_nb;
  logic [EW-1:0]      rd_entry;
  logic               full, empty;
  logic               push, pop, drop, push_req, xfer, last;

  // Byte count is latched with the pixel so later mode changes leave queued entries alone.
  always_comb begin
    wr_px = '0;
    wr_nb = NB_W'(1);
    if (sel_t'(select_i) == SEL_BYPASS) begin
      wr_px = px_i;
      wr_nb = NB_W'(NBYTES);
    end else begin
      wr_px[7:0] = px_i[7:0] & OUT_MASK;
    end
  end

  assign xfer     = (state == SEND) && byte_ready_i;
  assign last     = (idx_q == nbytes_q - NB_W'(1));
  assign pop      = !flush_i && !empty && ((state == IDLE) || (xfer && last));
  assign push_req = px_valid_i && !flush_i;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  px_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .flush_i   (flush_i),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i ({wr_px, wr_nb}),
    .rd_data_o (rd_entry),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state      <= IDLE;
      shift_q    <= '0;
      nbytes_q   <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      state      <= IDLE;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            shift_q  <= rd_entry[EW-1:NB_W];
            nbytes_q <= rd_entry[NB_W-1:0];
            idx_q    <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!last) begin
              shift_q <= shift_q >> 8;
              idx_q   <= idx_q + NB_W'(1);
            end else if (pop) begin
              shift_q  <= rd_entry[EW-1:NB_W];
              nbytes_q <= rd_entry[NB_W-1:0];
              idx_q    <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_o       = shift_q[7:0];
  assign byte_valid_o = (state == SEND);
  assign fifo_full_o  = full;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state == SEND) || !empty;

endmodule

// File: tb/tb_pixel_byte_serializer.sv
// tb/tb_pixel_byte_serializer.sv - directed scoreboard bench for pixel_byte_serializer
module tb_pixel_byte_serializer;

  logic        clk = 1'b0;
  logic        nreset;
  logic [1:0]  select;
  logic        px_valid;
  logic [23:0] px;
  logic        flush;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        fifo_full;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  pixel_byte_serializer #(
    .PIXEL_W    (24),
    .PX_OUT_W   (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .select_i     (select),
    .px_valid_i   (px_valid),
    .px_i         (px),
    .flush_i      (flush),
    .byte_o       (byte_out),
    .byte_valid_o (byte_valid),
    .byte_ready_i (byte_ready),
    .fifo_full_o  (fifo_full),
    .overflow_o   (overflow),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input logic [23:0] value);
    px_valid = 1'b1;
    px       = value;
    step();
    px_valid = 1'b0;
  endtask

  // Scoreboard: every accepted byte is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (nreset && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'h0, byte_out}, 32'hFFFF_FFFF);
      end else begin
        check("byte_stream", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    nreset = 1'b0; select = 2'b01; px_valid = 1'b0; px = '0; flush = 1'b0; byte_ready = 1'b1;
    #2;
    check("reset_byte",     {24'h0, byte_out}, 32'h0);
    check("reset_valid",    {31'h0, byte_valid}, 32'h0);
    check("reset_full",     {31'h0, fifo_full}, 32'h0);
    check("reset_overflow", {31'h0, overflow}, 32'h0);
    check("reset_busy",     {31'h0, busy}, 32'h0);
    step(); step();
    nreset = 1'b1;
    step();

    // Sobel single narrow pixel
    exp_q.push_back(8'h5A);
    push_px(24'h00005A);
    check("sobel_no_valid_yet", {31'h0, byte_valid}, 32'h0);
    check("sobel_busy_queued",  {31'h0, busy}, 32'h1);
    step();
    check("sobel_valid", {31'h0, byte_valid}, 32'h1);
    check("sobel_byte",  {24'h0, byte_out}, 32'h5A);
    step();
    check("sobel_valid_drop", {31'h0, byte_valid}, 32'h0);
    check("sobel_busy_drop",  {31'h0, busy}, 32'h0);

    // Bypass: two pixels back to back with no bubble
    select = 2'b11;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    push_px(24'hC3B2A1);
    px_valid = 1'b1; px = 24'h030201;
    step();
    px_valid = 1'b0;
    check("byp_b0", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hA1});
    step(); check("byp_b1", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hB2});
    step(); check("byp_b2", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hC3});
    step(); check("byp_p2_b0", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'h01});
    step(); check("byp_p2_b1", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'h02});
    step(); check("byp_p2_b2", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'h03});
    step(); check("byp_idle", {31'h0, byte_valid}, 32'h0);

    // Backpressure in the middle of a bypass pixel
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    push_px(24'hC3B2A1);
    step();
    step();
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hB2});
    end
    byte_ready = 1'b1;
    step(); check("bp_resume", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hC3});
    step(); check("bp_idle", {31'h0, byte_valid}, 32'h0);

    // Overflow with narrow pixels; upper pixel bits must not leak out
    select = 2'b00;
    byte_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      push_px(24'hABCD00 | 24'(i));
    end
    check("ovf_full",        {31'h0, fifo_full}, 32'h1);
    check("ovf_not_yet",     {31'h0, overflow}, 32'h0);
    check("ovf_head_byte",   {24'h0, byte_out}, 32'h01);
    push_px(24'hABCD06);
    check("ovf_set",         {31'h0, overflow}, 32'h1);
    byte_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("ovf_drained",     {31'h0, byte_valid}, 32'h0);
    check("ovf_sticky",      {31'h0, overflow}, 32'h1);
    check("ovf_queue_empty", exp_q.size(), 32'h0);

    // Flush during SEND with three entries queued and a simultaneous push
    select = 2'b01;
    byte_ready = 1'b0;
    push_px(24'h000011); push_px(24'h000012); push_px(24'h000013); push_px(24'h000014);
    check("fl_sending", {31'h0, byte_valid}, 32'h1);
    flush = 1'b1; px_valid = 1'b1; px = 24'h000099;
    step();
    flush = 1'b0; px_valid = 1'b0;
    check("fl_valid",    {31'h0, byte_valid}, 32'h0);
    check("fl_busy",     {31'h0, busy}, 32'h0);
    check("fl_overflow", {31'h0, overflow}, 32'h0);
    check("fl_full",     {31'h0, fifo_full}, 32'h0);
    byte_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("fl_silent", {31'h0, byte_valid}, 32'h0);

    // Asynchronous reset after the first byte of a bypass pixel
    select = 2'b11;
    exp_q.push_back(8'hA1);
    push_px(24'hC3B2A1);
    step();
    step();
    check("rst_pre_b1", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hB2});
    #2 nreset = 1'b0;
    #1;
    check("rst_async_byte",  {24'h0, byte_out}, 32'h0);
    check("rst_async_valid", {31'h0, byte_valid}, 32'h0);
    check("rst_async_busy",  {31'h0, busy}, 32'h0);
    step(); step();
    nreset = 1'b1;
    select = 2'b01;
    exp_q.push_back(8'h33);
    push_px(24'h000033);
    step();
    check("rst_new_px", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'h33});
    step(); check("rst_only_one", {31'h0, byte_valid}, 32'h0);
    for (int i = 0; i < 3; i++) step();
    check("final_queue_empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
